// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the sky130 1rw1r port-0 arbiter.
// Holds width defaults, requester ids and the request bundle.
package sram_arb_pkg;

   localparam int DEF_ADDR_WIDTH = 9;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;

   // A requester may hold at most this many buffered + in-flight reads
   localparam logic [1:0] CREDIT_MAX = 2'd2;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

   typedef struct packed {
      logic                      write;
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0] wdata;
      logic [DEF_NUM_WMASKS-1:0] wmask;
   } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo2.sv
// Two-entry read-response FIFO with occupancy count.
// Push and pop may happen together, including when full.
module sram_rsp_fifo2
   import sram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic [1:0]            count
);

   logic [DATA_WIDTH-1:0] mem [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign do_pop   = pop && (count != 2'd0);
   assign do_push  = push && ((count != 2'd2) || do_pop);
   assign pop_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   // Storage needs no reset: entries are only read while counted
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/sram_rw_port_arbiter.sv
// Round-robin arbiter/sequencer for port 0 of the OpenRAM 1rw1r macro.
// Issues reads under a 2-credit limit and buffers responses per requester.
module sram_rw_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_req_valid,
   output logic                  a_req_ready,
   input  logic                  a_req_write,
   input  logic [ADDR_WIDTH-1:0] a_req_addr,
   input  logic [DATA_WIDTH-1:0] a_req_wdata,
   input  logic [NUM_WMASKS-1:0] a_req_wmask,
   output logic                  a_rsp_valid,
   input  logic                  a_rsp_ready,
   output logic [DATA_WIDTH-1:0] a_rsp_rdata,
   input  logic                  b_req_valid,
   output logic                  b_req_ready,
   input  logic                  b_req_write,
   input  logic [ADDR_WIDTH-1:0] b_req_addr,
   input  logic [DATA_WIDTH-1:0] b_req_wdata,
   input  logic [NUM_WMASKS-1:0] b_req_wmask,
   output logic                  b_rsp_valid,
   input  logic                  b_rsp_ready,
   output logic [DATA_WIDTH-1:0] b_rsp_rdata,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);

   sram_req_t a_req;
   sram_req_t b_req;
   sram_req_t sel_req;

   req_id_t last;
   req_id_t gnt_id;
   req_id_t infl_id;
   logic    infl_v;

   logic [1:0] a_cnt;
   logic [1:0] b_cnt;
   logic [1:0] a_credits;
   logic [1:0] b_credits;
   logic       a_pop;
   logic       b_pop;
   logic       a_push;
   logic       b_push;
   logic       a_elig;
   logic       b_elig;
   logic       grant_a;
   logic       grant_b;
   logic       grant_any;

   logic [NUM_WMASKS-1:0] hold_wmask;
   logic [ADDR_WIDTH-1:0] hold_addr;
   logic [DATA_WIDTH-1:0] hold_din;

   assign a_req = '{
      write: a_req_write,
      addr:  a_req_addr,
      wdata: a_req_wdata,
      wmask: a_req_wmask
   };
   assign b_req = '{
      write: b_req_write,
      addr:  b_req_addr,
      wdata: b_req_wdata,
      wmask: b_req_wmask
   };

   assign a_pop  = a_rsp_valid && a_rsp_ready;
   assign b_pop  = b_rsp_valid && b_rsp_ready;
   assign a_push = infl_v && (infl_id == REQ_A);
   assign b_push = infl_v && (infl_id == REQ_B);

   // A pop frees its credit in the same cycle it happens
   assign a_credits = a_cnt + {1'b0, a_push} - {1'b0, a_pop};
   assign b_credits = b_cnt + {1'b0, b_push} - {1'b0, b_pop};

   assign a_elig = a_req_valid &&
                   (a_req_write || (a_credits < CREDIT_MAX));
   assign b_elig = b_req_valid &&
                   (b_req_write || (b_credits < CREDIT_MAX));

   // Round-robin grant; nothing is granted while reset is held
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (rst_n) begin
         grant_a = a_elig && (!b_elig || (last == REQ_B));
         grant_b = b_elig && (!a_elig || (last == REQ_A));
      end
   end

   assign grant_any   = grant_a || grant_b;
   assign a_req_ready = grant_a;
   assign b_req_ready = grant_b;

   // Steer the granted request onto the macro pins, else hold them
   always_comb begin
      sel_req     = a_req;
      gnt_id      = REQ_A;
      sram_csb0   = 1'b1;
      sram_web0   = 1'b1;
      sram_wmask0 = hold_wmask;
      sram_addr0  = hold_addr;
      sram_din0   = hold_din;
      unique case (1'b1)
         grant_a: begin
            sel_req = a_req;
            gnt_id  = REQ_A;
         end
         grant_b: begin
            sel_req = b_req;
            gnt_id  = REQ_B;
         end
         default: ;
      endcase
      if (grant_any) begin
         sram_csb0   = 1'b0;
         sram_web0   = !sel_req.write;
         sram_wmask0 = sel_req.write ? sel_req.wmask : '1;
         sram_addr0  = sel_req.addr;
         sram_din0   = sel_req.wdata;
      end
   end

   // Round-robin pointer and read in-flight tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last    <= REQ_B;
         infl_v  <= 1'b0;
         infl_id <= REQ_A;
      end else begin
         if (grant_any) last <= gnt_id;
         infl_v  <= grant_any && !sel_req.write;
         infl_id <= gnt_id;
      end
   end

   // Keep the data-side pins stable while the port is idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_wmask <= '0;
         hold_addr  <= '0;
         hold_din   <= '0;
      end else if (grant_any) begin
         hold_wmask <= sram_wmask0;
         hold_addr  <= sram_addr0;
         hold_din   <= sram_din0;
      end
   end

   sram_rsp_fifo2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (a_push),
      .push_data (sram_dout0),
      .pop       (a_pop),
      .pop_data  (a_rsp_rdata),
      .count     (a_cnt)
   );

   sram_rsp_fifo2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (b_push),
      .push_data (sram_dout0),
      .pop       (b_pop),
      .pop_data  (b_rsp_rdata),
      .count     (b_cnt)
   );

   assign a_rsp_valid = (a_cnt != 2'd0);
   assign b_rsp_valid = (b_cnt != 2'd0);

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// Directed bench for sram_rw_port_arbiter with a behavioural macro.
// Macro captures at posedge and performs the access at the negedge.
module tb_sram_rw_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        a_req_valid;
   logic        a_req_ready;
   logic        a_req_write;
   logic [8:0]  a_req_addr;
   logic [31:0] a_req_wdata;
   logic [3:0]  a_req_wmask;
   logic        a_rsp_valid;
   logic        a_rsp_ready;
   logic [31:0] a_rsp_rdata;
   logic        b_req_valid;
   logic        b_req_ready;
   logic        b_req_write;
   logic [8:0]  b_req_addr;
   logic [31:0] b_req_wdata;
   logic [3:0]  b_req_wmask;
   logic        b_rsp_valid;
   logic        b_rsp_ready;
   logic [31:0] b_rsp_rdata;
   logic        sram_csb0;
   logic        sram_web0;
   logic [3:0]  sram_wmask0;
   logic [8:0]  sram_addr0;
   logic [31:0] sram_din0;
   logic [31:0] sram_dout0;

   int checks;
   int failures;

   sram_rw_port_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a_req_valid (a_req_valid),
      .a_req_ready (a_req_ready),
      .a_req_write (a_req_write),
      .a_req_addr  (a_req_addr),
      .a_req_wdata (a_req_wdata),
      .a_req_wmask (a_req_wmask),
      .a_rsp_valid (a_rsp_valid),
      .a_rsp_ready (a_rsp_ready),
      .a_rsp_rdata (a_rsp_rdata),
      .b_req_valid (b_req_valid),
      .b_req_ready (b_req_ready),
      .b_req_write (b_req_write),
      .b_req_addr  (b_req_addr),
      .b_req_wdata (b_req_wdata),
      .b_req_wmask (b_req_wmask),
      .b_rsp_valid (b_rsp_valid),
      .b_rsp_ready (b_rsp_ready),
      .b_rsp_rdata (b_rsp_rdata),
      .sram_csb0   (sram_csb0),
      .sram_web0   (sram_web0),
      .sram_wmask0 (sram_wmask0),
      .sram_addr0  (sram_addr0),
      .sram_din0   (sram_din0),
      .sram_dout0  (sram_dout0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [512];
   logic        cap_csb;
   logic        cap_web;
   logic [3:0]  cap_wmask;
   logic [8:0]  cap_addr;
   logic [31:0] cap_din;

   initial begin
      cap_csb    = 1'b1;
      cap_web    = 1'b1;
      cap_wmask  = '0;
      cap_addr   = '0;
      cap_din    = '0;
      sram_dout0 = '0;
   end

   always @(posedge clk) begin
      cap_csb   <= sram_csb0;
      cap_web   <= sram_web0;
      cap_wmask <= sram_wmask0;
      cap_addr  <= sram_addr0;
      cap_din   <= sram_din0;
   end

   always @(negedge clk) begin
      if (!cap_csb) begin
         if (!cap_web) begin
            for (int i = 0; i < 4; i++)
               if (cap_wmask[i])
                  mem[cap_addr][i*8 +: 8] <= cap_din[i*8 +: 8];
         end else begin
            sram_dout0 <= mem[cap_addr];
         end
      end
   end

   function automatic logic [31:0] pat(input int k);
      return {8'hA5, 8'(k), 8'h3C, 8'(k) ^ 8'hFF};
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic bp_step(input logic       rv,
                          input logic       rr,
                          input int         addr,
                          input logic       e_rdy,
                          input logic       e_rv,
                          input int         e_k);
      tick();
      a_req_valid = rv;
      a_req_write = 1'b0;
      a_req_addr  = 9'(addr);
      a_rsp_ready = rr;
      #1;
      chk("bp_ready", 32'(a_req_ready), 32'(e_rdy));
      chk("bp_rsp_valid", 32'(a_rsp_valid), 32'(e_rv));
      if (e_rv) chk("bp_rdata", a_rsp_rdata, pat(e_k));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int ka;
      int kb;
      int ra;
      int rb;
      logic ea;
      logic eb;
      logic av;
      logic bv;

      checks      = 0;
      failures    = 0;
      for (int i = 0; i < 512; i++) mem[i] = pat(i);
      mem[5]      = 32'hDEADBEEF;
      mem[7]      = 32'hFFFFFFFF;
      rst_n       = 1'b0;
      a_req_valid = 1'b1;
      b_req_valid = 1'b1;
      a_req_write = 1'b0;
      b_req_write = 1'b0;
      a_req_addr  = '0;
      b_req_addr  = '0;
      a_req_wdata = '0;
      b_req_wdata = '0;
      a_req_wmask = '0;
      b_req_wmask = '0;
      a_rsp_ready = 1'b1;
      b_rsp_ready = 1'b1;

      #2;
      chk("rst_a_ready", 32'(a_req_ready), 0);
      chk("rst_b_ready", 32'(b_req_ready), 0);
      chk("rst_a_rsp", 32'(a_rsp_valid), 0);
      chk("rst_b_rsp", 32'(b_rsp_valid), 0);
      chk("rst_csb", 32'(sram_csb0), 1);
      chk("rst_web", 32'(sram_web0), 1);

      tick();
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      tick();
      rst_n = 1'b1;

      // single read of preloaded word
      tick();
      a_req_valid = 1'b1;
      a_req_addr  = 9'd5;
      #1;
      chk("rd_ready", 32'(a_req_ready), 1);
      chk("rd_csb", 32'(sram_csb0), 0);
      chk("rd_web", 32'(sram_web0), 1);
      chk("rd_addr", 32'(sram_addr0), 5);
      chk("rd_wmask", 32'(sram_wmask0), 32'hF);
      tick();
      a_req_valid = 1'b0;
      #1;
      chk("rd_c1_csb", 32'(sram_csb0), 1);
      chk("rd_c1_valid", 32'(a_rsp_valid), 0);
      tick();
      #1;
      chk("rd_c2_valid", 32'(a_rsp_valid), 1);
      chk("rd_c2_data", a_rsp_rdata, 32'hDEADBEEF);
      tick();
      #1;
      chk("rd_c3_valid", 32'(a_rsp_valid), 0);

      // masked write then read-back
      tick();
      a_req_valid = 1'b1;
      a_req_write = 1'b1;
      a_req_addr  = 9'd7;
      a_req_wdata = 32'h11223344;
      a_req_wmask = 4'b0101;
      #1;
      chk("wr_ready", 32'(a_req_ready), 1);
      chk("wr_csb", 32'(sram_csb0), 0);
      chk("wr_web", 32'(sram_web0), 0);
      chk("wr_wmask", 32'(sram_wmask0), 32'h5);
      chk("wr_din", sram_din0, 32'h11223344);
      tick();
      a_req_write = 1'b0;
      #1;
      chk("wrd_ready", 32'(a_req_ready), 1);
      chk("wrd_web", 32'(sram_web0), 1);
      tick();
      a_req_valid = 1'b0;
      #1;
      tick();
      #1;
      chk("wrd_valid", 32'(a_rsp_valid), 1);
      chk("wrd_data", a_rsp_rdata, 32'hFF22FF44);

      // idle: pins hold the last granted values
      for (int i = 0; i < 4; i++) begin
         tick();
         a_req_addr  = 9'(i * 37 + 100);
         a_req_wdata = $urandom;
         a_req_wmask = 4'(i);
         #1;
         chk("idle_csb", 32'(sram_csb0), 1);
         chk("idle_web", 32'(sram_web0), 1);
         chk("idle_addr", 32'(sram_addr0), 7);
         chk("idle_wmask", 32'(sram_wmask0), 32'hF);
         chk("idle_din", sram_din0, 32'h11223344);
      end

      // reset the cycle after a read grant
      tick();
      a_req_valid = 1'b1;
      a_req_write = 1'b0;
      a_req_addr  = 9'd5;
      #1;
      chk("mr_grant", 32'(a_req_ready), 1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("mr_ready", 32'(a_req_ready), 0);
      chk("mr_csb", 32'(sram_csb0), 1);
      chk("mr_web", 32'(sram_web0), 1);
      chk("mr_rsp", 32'(a_rsp_valid), 0);
      tick();
      a_req_valid = 1'b0;
      #1;
      chk("mr_rsp_hold", 32'(a_rsp_valid), 0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("mr_rsp_rel", 32'(a_rsp_valid), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         chk("mr_rsp_after", 32'(a_rsp_valid), 0);
      end

      // contention: both read, A first after reset
      ka = 0;
      kb = 0;
      ra = 0;
      rb = 0;
      for (int c = 0; c < 9; c++) begin
         tick();
         a_req_valid = (c < 6);
         b_req_valid = (c < 6);
         a_req_write = 1'b0;
         b_req_write = 1'b0;
         a_req_addr  = 9'(32 + ka);
         b_req_addr  = 9'(64 + kb);
         #1;
         ea = (c < 6) && (c % 2 == 0);
         eb = (c < 6) && (c % 2 == 1);
         av = (c >= 2) && (c <= 6) && (c % 2 == 0);
         bv = (c >= 3) && (c <= 7) && (c % 2 == 1);
         chk("ct_a_ready", 32'(a_req_ready), 32'(ea));
         chk("ct_b_ready", 32'(b_req_ready), 32'(eb));
         if (ea) chk("ct_addr_a", 32'(sram_addr0), 32 + ka);
         if (eb) chk("ct_addr_b", 32'(sram_addr0), 64 + kb);
         chk("ct_a_rsp", 32'(a_rsp_valid), 32'(av));
         chk("ct_b_rsp", 32'(b_rsp_valid), 32'(bv));
         if (av) begin
            chk("ct_a_data", a_rsp_rdata, pat(32 + ra));
            ra++;
         end
         if (bv) begin
            chk("ct_b_data", b_rsp_rdata, pat(64 + rb));
            rb++;
         end
         if (ea) ka++;
         if (eb) kb++;
      end

      // backpressure: two credits, one more read per pop
      //       valid rsp_rdy addr rdy rspv data
      bp_step(1'b1, 1'b0, 48, 1'b1, 1'b0, 0);
      bp_step(1'b1, 1'b0, 49, 1'b1, 1'b0, 0);
      bp_step(1'b1, 1'b0, 50, 1'b0, 1'b1, 48);
      bp_step(1'b1, 1'b0, 50, 1'b0, 1'b1, 48);
      bp_step(1'b1, 1'b0, 50, 1'b0, 1'b1, 48);
      bp_step(1'b1, 1'b0, 50, 1'b0, 1'b1, 48);
      bp_step(1'b1, 1'b1, 50, 1'b1, 1'b1, 48);
      bp_step(1'b1, 1'b0, 51, 1'b0, 1'b1, 49);
      bp_step(1'b1, 1'b0, 51, 1'b0, 1'b1, 49);
      bp_step(1'b1, 1'b1, 51, 1'b1, 1'b1, 49);
      bp_step(1'b0, 1'b1, 51, 1'b0, 1'b1, 50);
      bp_step(1'b0, 1'b1, 51, 1'b0, 1'b1, 51);
      bp_step(1'b0, 1'b1, 51, 1'b0, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_rw_port_arbiter.md
# sram_rw_port_arbiter

Two-requester arbiter and sequencer for the read/write port (port 0) of the sky130 OpenRAM 1rw1r macro. It accepts read and write requests from requesters A and B with valid/ready handshakes. It grants the single RW port round-robin and drives the macro's active-low control pins. It captures read data with the macro's fixed latency and returns it in order per requester through a 2-entry response buffer. It sits between the bus-side client logic and the SRAM macro instance, and port 1 stays untouched.

## Interface
- ADDR_WIDTH, 9, word address width.
- DATA_WIDTH, 32, data width.
- NUM_WMASKS, 4, byte-lane write mask width (DATA_WIDTH/8).
- CLK  in  1  single clock; also drives the macro's clk0.
- RST_N  in  1  reset, asynchronous, active-low.
- a_req_valid / b_req_valid  in  1  request present.
- a_req_ready / b_req_ready  out  1  request accepted this cycle.
- a_req_write / b_req_write  in  1  1 = write, 0 = read.
- a_req_addr / b_req_addr  in  ADDR_WIDTH  word address.
- a_req_wdata / b_req_wdata  in  DATA_WIDTH  write data.
- a_req_wmask / b_req_wmask  in  NUM_WMASKS  byte enables; ignored on reads.
- a_rsp_valid / b_rsp_valid  out  1  read data available.
- a_rsp_ready / b_rsp_ready  in  1  requester consumes read data.
- a_rsp_rdata / b_rsp_rdata  out  DATA_WIDTH  read data.
- sram_csb0  out  1  macro chip select, active-low.
- sram_web0  out  1  macro write enable, active-low.
- sram_wmask0  out  NUM_WMASKS  to macro.
- sram_addr0  out  ADDR_WIDTH  to macro.
- sram_din0  out  DATA_WIDTH  to macro.
- sram_dout0  in  DATA_WIDTH  from macro.

## Operation
- **Writes are posted.** A write produces no response.
- **Read issue limit.** Each requester holds a read credit count: buffered responses plus reads in flight, at most 2. A read is eligible only when this count is below 2. A write is always eligible.
- **Arbitration.** Round-robin between eligible requesters; `last` register is 1 bit.
  - Both requesters eligible: grant the one not equal to `last`.
  - One requester eligible: grant it.
  - `last` updates on every grant.
  - Reset value of `last` = B, so A wins the first tie.
- **Handshake.** `x_req_ready = grant_x`. This is combinational from `x_req_valid`, eligibility and `last`. A request transfers when valid && ready.
- **Driving the macro.** The granted request drives the sram_* pins combinationally in the same cycle.
  - sram_csb0 = 0, sram_web0 = !write.
  - sram_wmask0 = wmask on a write; all ones on a read.
  - No grant: sram_csb0 = 1, sram_web0 = 1; the other sram_* pins hold the last value (no toggling).
- **Read tracking.** A 1-entry in-flight register {valid, id} is set on a read grant. The next cycle it pushes sram_dout0 into the FIFO of that id.
- **Response buffer.** Per-requester 2-entry FIFO; `x_rsp_valid` = FIFO not empty. A pop occurs on rsp_valid && rsp_ready. Credits free on the pop.
- **Ordering.** Same-address write followed by a read, on any requester, returns the new data. The macro commits the write at the negedge before the read is captured, so no bypass is needed.
- **Reset (async, RST_N low).**
  - FIFOs, in-flight register and `last` clear immediately.
  - All ready/rsp_valid outputs = 0; sram_csb0 = 1, sram_web0 = 1.
  - Reset mid-read discards the in-flight data.

## Timing
- Request accepted in cycle N → macro captures it at the posedge ending cycle N.
- Read data is sampled at the posedge ending N+1, and rsp_valid rises in N+2.
- Read latency is 2 cycles, with 1 read/cycle sustained throughput when only one requester issues and rsp_ready is held high.
- Sampling sram_dout0 at the posedge is safe because the macro holds dout0 until T_HOLD after that edge.
- Response pop and credit refill happen in the same cycle, so a full FIFO with rsp_ready = 1 does not stall eligibility.

## Structure
- Package `sram_arb_pkg`:
  - default width constants;
  - `req_id_t` enum {REQ_A, REQ_B};
  - request struct {write, addr, wdata, wmask}.
- Sub-module `sram_rsp_fifo2`: 2-entry FIFO with count output, instanced once per requester.
- The arbiter, credit counters and in-flight register live in the top module.

## Test plan
- **Single read.** Preload mem[5] = 0xDEADBEEF; A reads addr 5 in cycle 0 → a_rsp_rdata = 0xDEADBEEF with a_rsp_valid in cycle 2; sram_csb0 low in cycle 0 only.
- **Masked write then read.** A writes 0x11223344 to addr 7 with wmask 4'b0101 over 0xFFFFFFFF; next cycle A reads addr 7 → 0xFF22FF44.
- **Contention.** A and B both hold valid reads for 6 cycles → grants alternate A, B, A, …, A first after reset; each requester gets its data in order, 2 cycles after its grant.
- **Backpressure.** A issues 4 back-to-back reads with a_rsp_ready = 0 → only 2 accepted; a_req_ready stays 0 until a_rsp_ready pulses, then one more read is accepted per pop.
- **Reset mid-read.** Assert RST_N low the cycle after a read grant → a_rsp_valid never rises; sram_csb0 = 1 immediately; after release the first tie goes to A.
- **Idle.** No valids → sram_csb0 = 1 and sram_web0 = 1 every cycle; the other sram_* pins are stable.
